// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (common with ALU_Control) and the
// execute-stage FSM encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDR = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations and signed overflow. Shift codes are legal
// here but produce 0; the execute stage runs them on its own shifter.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             illegal
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  // Shared adder: SUB adds the two's complement of B.
  always_comb begin
    b_eff   = (alu_ctrl == ALU_SUB) ? (~op_b + WIDTH'(1)) : op_b;
    sum     = op_a + b_eff;
    add_ovf = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  // Operation select; overflow is only reported for add/sub.
  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD, ALU_ADDR, ALU_SUB: begin
        res = sum;
        ovf = add_ovf;
      end
      ALU_AND: res = op_a & op_b;
      ALU_OR:  res = op_a | op_b;
      ALU_NOR: res = ~(op_a | op_b);
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL, ALU_SRL: res = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered result with valid/ready on both sides.
// Logical shifts run 1 bit per cycle from a working register.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no result held, ready for a new op
//   ST_SHIFT | iterative shift in progress, upstream stalled
//   ST_HOLD  | result valid, held until consumer takes it
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             dir_right_q;

  logic             accept;
  logic             shift_op;
  logic             shift_last;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] core_res;
  logic             core_ovf;
  logic             core_ill;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .res      (core_res),
    .ovf      (core_ovf),
    .illegal  (core_ill)
  );

  // Handshake and shifter control decode.
  always_comb begin
    in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    out_valid  = (state_q == ST_HOLD);
    accept     = in_valid && in_ready;
    shift_op   = is_shift(alu_ctrl);
    shift_last = (cnt_q == SHW'(1));
    work_nxt   = dir_right_q ? (work_q >> 1) : (work_q << 1);
  end

  // Next-state logic; HOLD accepts back-to-back exactly like IDLE.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          state_n = (shift_op && (shamt != '0)) ? ST_SHIFT : ST_HOLD;
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: if (shift_last) state_n = ST_HOLD;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Result/flag registers and the iterative shifter; the last shift step
  // writes straight into result so HOLD follows the final shift directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      illegal     <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else if (accept) begin
      if (shift_op) begin
        overflow <= 1'b0;
        illegal  <= 1'b0;
        if (shamt == '0) begin
          result <= op_b;
          zero   <= (op_b == '0);
        end else begin
          result      <= '0;
          zero        <= 1'b0;
          work_q      <= op_b;
          cnt_q       <= shamt;
          dir_right_q <= (alu_ctrl == ALU_SRL);
        end
      end else begin
        result   <= core_res;
        zero     <= (core_res == '0);
        overflow <= core_ovf;
        illegal  <= core_ill;
      end
    end else if (state_q == ST_SHIFT) begin
      work_q <= work_nxt;
      cnt_q  <= cnt_q - SHW'(1);
      if (shift_last) begin
        result <= work_nxt;
        zero   <= (work_nxt == '0);
      end
    end
  end

endmodule
